axi4lite_master: RTL and testbench

//  AXI4-Lite master: turns single-beat commands from a local bus (test sequencer, debug bridge, CPU glue)

---
 rtl/axi4lite_master.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_axi4lite_master.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/axi4lite_master.sv
// AXI4-Lite master: converts single-beat local-bus commands into AXI4-Lite
// read/write transactions, one outstanding, with an optional response watchdog.
module axi4lite_master #(
    parameter int                    ADDRESS_WIDTH = 5,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    PROT_WIDTH    = 3,
    parameter int                    STRB_WIDTH    = DATA_WIDTH / 8,
    parameter logic [PROT_WIDTH-1:0] PROT_VALUE    = 3'b000,
    parameter int                    TIMEOUT       = 256
) (
    input  logic                     m_axi_aclk,
    input  logic                     m_axi_aresetn,
    // local command / response bus
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_we,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wdata,
    input  logic [STRB_WIDTH-1:0]    cmd_wstrb,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic [1:0]               rsp_resp,
    output logic                     rsp_timeout,
    // AXI4-Lite write address channel
    output logic                     m_axi_awvalid,
    output logic [ADDRESS_WIDTH-1:0] m_axi_awaddr,
    output logic [PROT_WIDTH-1:0]    m_axi_awprot,
    input  logic                     m_axi_awready,
    // AXI4-Lite write data channel
    output logic                     m_axi_wvalid,
    output logic [DATA_WIDTH-1:0]    m_axi_wdata,
    output logic [STRB_WIDTH-1:0]    m_axi_wstrb,
    input  logic                     m_axi_wready,
    // AXI4-Lite write response channel
    input  logic                     m_axi_bvalid,
    input  logic [1:0]               m_axi_bresp,
    output logic                     m_axi_bready,
    // AXI4-Lite read address channel
    output logic                     m_axi_arvalid,
    output logic [ADDRESS_WIDTH-1:0] m_axi_araddr,
    output logic [PROT_WIDTH-1:0]    m_axi_arprot,
    input  logic                     m_axi_arready,
    // AXI4-Lite read data channel
    input  logic                     m_axi_rvalid,
    input  logic [DATA_WIDTH-1:0]    m_axi_rdata,
    input  logic [1:0]               m_axi_rresp,
    output logic                     m_axi_rready
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
    localparam logic [1:0] RESP_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_RSP   = 3'd5,
        ST_DRAIN = 3'd6
    } state_t;

    state_t                   state_r;
    logic                     cmd_ready_r;
    logic                     we_r;
    logic [ADDRESS_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0]    wdata_r;
    logic [STRB_WIDTH-1:0]    wstrb_r;
    logic                     awvalid_r;
    logic                     wvalid_r;
    logic                     aw_done_r;
    logic                     w_done_r;
    logic                     arvalid_r;
    logic                     bready_r;
    logic                     rready_r;
    logic                     rsp_valid_r;
    logic [DATA_WIDTH-1:0]    rsp_rdata_r;
    logic [1:0]               rsp_resp_r;
    logic                     rsp_timeout_r;
    logic [CNT_W-1:0]         wd_cnt_r;

    logic aw_hs_s;
    logic w_hs_s;
    logic ar_hs_s;
    logic b_hs_s;
    logic r_hs_s;
    logic aw_fin_s;
    logic w_fin_s;
    logic wd_expire_s;

    assign aw_hs_s     = awvalid_r & m_axi_awready;
    assign w_hs_s      = wvalid_r & m_axi_wready;
    assign ar_hs_s     = arvalid_r & m_axi_arready;
    assign b_hs_s      = bready_r & m_axi_bvalid;
    assign r_hs_s      = rready_r & m_axi_rvalid;
    // the later of the two write handshakes may land in the current cycle
    assign aw_fin_s    = aw_done_r | aw_hs_s;
    assign w_fin_s     = w_done_r | w_hs_s;
    assign wd_expire_s = (TIMEOUT > 0) && (wd_cnt_r == WD_LAST);

    assign cmd_ready     = cmd_ready_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_rdata     = rsp_rdata_r;
    assign rsp_resp      = rsp_resp_r;
    assign rsp_timeout   = rsp_timeout_r;
    assign m_axi_awvalid = awvalid_r;
    assign m_axi_awaddr  = addr_r;
    assign m_axi_awprot  = PROT_VALUE;
    assign m_axi_wvalid  = wvalid_r;
    assign m_axi_wdata   = wdata_r;
    assign m_axi_wstrb   = wstrb_r;
    assign m_axi_bready  = bready_r;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_araddr  = addr_r;
    assign m_axi_arprot  = PROT_VALUE;
    assign m_axi_rready  = rready_r;

    // Transaction sequencer: state, channel handshakes, response capture and watchdog
    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            state_r       <= ST_IDLE;
            cmd_ready_r   <= 1'b1;
            we_r          <= 1'b0;
            addr_r        <= {ADDRESS_WIDTH{1'b0}};
            wdata_r       <= {DATA_WIDTH{1'b0}};
            wstrb_r       <= {STRB_WIDTH{1'b0}};
            awvalid_r     <= 1'b0;
            wvalid_r      <= 1'b0;
            aw_done_r     <= 1'b0;
            w_done_r      <= 1'b0;
            arvalid_r     <= 1'b0;
            bready_r      <= 1'b0;
            rready_r      <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
            rsp_resp_r    <= 2'b00;
            rsp_timeout_r <= 1'b0;
            wd_cnt_r      <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready_r <= 1'b0;
                        we_r        <= cmd_we;
                        addr_r      <= cmd_addr;
                        wdata_r     <= cmd_wdata;
                        wstrb_r     <= cmd_wstrb;
                        aw_done_r   <= 1'b0;
                        w_done_r    <= 1'b0;
                        if (cmd_we) begin
                            state_r   <= ST_WADDR;
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                        end else begin
                            state_r   <= ST_RADDR;
                            arvalid_r <= 1'b1;
                        end
                    end else begin
                        cmd_ready_r <= 1'b1;
                    end
                end

                ST_WADDR: begin
                    if (aw_hs_s) begin
                        awvalid_r <= 1'b0;
                        aw_done_r <= 1'b1;
                    end else begin
                        aw_done_r <= aw_done_r;
                    end
                    if (w_hs_s) begin
                        wvalid_r <= 1'b0;
                        w_done_r <= 1'b1;
                    end else begin
                        w_done_r <= w_done_r;
                    end
                    if (aw_fin_s && w_fin_s) begin
                        state_r  <= ST_WRESP;
                        bready_r <= 1'b1;
                        wd_cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        state_r <= ST_WADDR;
                    end
                end

                ST_RADDR: begin
                    if (ar_hs_s) begin
                        arvalid_r <= 1'b0;
                        state_r   <= ST_RDATA;
                        rready_r  <= 1'b1;
                        wd_cnt_r  <= {CNT_W{1'b0}};
                    end else begin
                        state_r <= ST_RADDR;
                    end
                end

                // a handshake in the expiry cycle still completes normally
                ST_WRESP: begin
                    if (b_hs_s) begin
                        bready_r      <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
                        rsp_resp_r    <= m_axi_bresp;
                        rsp_timeout_r <= 1'b0;
                        state_r       <= ST_RSP;
                    end else if (wd_expire_s) begin
                        bready_r      <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
                        rsp_resp_r    <= RESP_TIMEOUT;
                        rsp_timeout_r <= 1'b1;
                        state_r       <= ST_RSP;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end

                ST_RDATA: begin
                    if (r_hs_s) begin
                        rready_r      <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        rsp_rdata_r   <= m_axi_rdata;
                        rsp_resp_r    <= m_axi_rresp;
                        rsp_timeout_r <= 1'b0;
                        state_r       <= ST_RSP;
                    end else if (wd_expire_s) begin
                        rready_r      <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
                        rsp_resp_r    <= RESP_TIMEOUT;
                        rsp_timeout_r <= 1'b1;
                        state_r       <= ST_RSP;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end

                // after a timeout the late response must still be absorbed
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        if (rsp_timeout_r) begin
                            state_r  <= ST_DRAIN;
                            bready_r <= we_r;
                            rready_r <= ~we_r;
                        end else begin
                            state_r     <= ST_IDLE;
                            cmd_ready_r <= 1'b1;
                        end
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (b_hs_s || r_hs_s) begin
                        bready_r    <= 1'b0;
                        rready_r    <= 1'b0;
                        state_r     <= ST_IDLE;
                        cmd_ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end

                default: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b1;
                    awvalid_r   <= 1'b0;
                    wvalid_r    <= 1'b0;
                    arvalid_r   <= 1'b0;
                    bready_r    <= 1'b0;
                    rready_r    <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_master.sv
// Self-checking bench for axi4lite_master: directed scenarios plus randomized
// transactions checked cycle by cycle against arithmetic timing predictions.
module tb_axi4lite_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    axi4lite_master #(.TIMEOUT(TO)) dut (
        .m_axi_aclk(clk), .m_axi_aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axi_awvalid(awvalid), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awready(awready),
        .m_axi_wvalid(wvalid), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wready(wready),
        .m_axi_bvalid(bvalid), .m_axi_bresp(bresp), .m_axi_bready(bready),
        .m_axi_arvalid(arvalid), .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arready(arready),
        .m_axi_rvalid(rvalid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rready(rready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction; all expected timing derived from handshake delays.
    // awd/wdl/ard: cycles the slave waits before accepting; dly: cycles after
    // the response phase opens before B/R valid; hold: cycles rsp_ready stays low.
    task automatic run_txn(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                           input logic [3:0] strb, input int awd, input int wdl, input int ard,
                           input int dly, input int hold, input logic [1:0] resp,
                           input logic [31:0] rdat, input string name);
        int aw_hs, w_hs, ar_hs, s, v, rdy_end, rsp_start, rsp_end, d_hs, bv_end, idle;
        bit to;
        logic [31:0] e_rdata;
        logic [1:0]  e_resp;
        logic e_aw, e_w, e_ar, e_rdy, e_rv, e_cr;
        aw_hs = 1 + awd;
        w_hs  = 1 + wdl;
        ar_hs = 1 + ard;
        s     = we ? ((aw_hs > w_hs ? aw_hs : w_hs) + 1) : (ar_hs + 1);
        v     = s + dly;
        to    = (dly >= TO);
        if (to) begin
            rdy_end   = s + TO - 1;
            rsp_start = s + TO;
        end else begin
            rdy_end   = v;
            rsp_start = v + 1;
        end
        rsp_end = rsp_start + hold;
        d_hs    = to ? ((rsp_end + 1 > v) ? rsp_end + 1 : v) : 0;
        bv_end  = to ? d_hs : v;
        idle    = to ? d_hs + 1 : rsp_end + 1;
        e_rdata = (to || we) ? 32'h0 : rdat;
        e_resp  = to ? 2'b11 : resp;

        check({name, " cmd_ready at offer"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_wstrb = strb;
        for (int n = 1; n <= idle; n++) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            cmd_addr  = 5'($urandom);
            cmd_wdata = $urandom;
            e_aw  = we && (n <= aw_hs);
            e_w   = we && (n <= w_hs);
            e_ar  = !we && (n <= ar_hs);
            e_rdy = ((n >= s) && (n <= rdy_end)) || (to && (n > rsp_end) && (n <= d_hs));
            e_rv  = (n >= rsp_start) && (n <= rsp_end);
            e_cr  = (n == idle);
            check($sformatf("%s ctrl{aw,w,ar,b,r,rsp,cmd} cyc %0d", name, n),
                  64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}),
                  64'({e_aw, e_w, e_ar, we && e_rdy, !we && e_rdy, e_rv, e_cr}));
            if (e_aw) check($sformatf("%s aw payload cyc %0d", name, n), 64'({awaddr, awprot}), 64'({addr, 3'b000}));
            if (e_w)  check($sformatf("%s w payload cyc %0d", name, n), 64'({wdata, wstrb}), 64'({wd, strb}));
            if (e_ar) check($sformatf("%s ar payload cyc %0d", name, n), 64'({araddr, arprot}), 64'({addr, 3'b000}));
            if (e_rv) check($sformatf("%s rsp{rdata,resp,to} cyc %0d", name, n),
                            64'({rsp_rdata, rsp_resp, rsp_timeout}), 64'({e_rdata, e_resp, to}));
            awready   = we && (n == aw_hs);
            wready    = we && (n == w_hs);
            arready   = !we && (n == ar_hs);
            bvalid    = we && (n >= v) && (n <= bv_end);
            bresp     = resp;
            rvalid    = !we && (n >= v) && (n <= bv_end);
            rdata     = rvalid ? rdat : $urandom;
            rresp     = resp;
            rsp_ready = (n >= rsp_start + hold) && (n < idle);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic we;
        int dly;
        aresetn = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 5'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
        rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("reset ctrl", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}), 64'h01);
        check("reset rsp regs", 64'({rsp_rdata, rsp_resp, rsp_timeout}), 64'h0);
        aresetn = 1'b1;

        // directed scenarios
        run_txn(1'b1, 5'h00, 32'h0000_0041, 4'b0001, 0, 0, 0, 0, 0, 2'b00, 32'h0, "t1_write");
        run_txn(1'b0, 5'h14, 32'h0, 4'h0, 0, 0, 0, 5, 0, 2'b00, 32'h0000_0060, "t2_read");
        run_txn(1'b1, 5'h08, 32'hDEAD_BEEF, 4'b1111, 0, 3, 0, 0, 0, 2'b00, 32'h0, "t3_split");
        run_txn(1'b1, 5'h0C, 32'h1234_5678, 4'b0110, 2, 0, 0, 1, 3, 2'b10, 32'h0, "t4_slverr");
        run_txn(1'b0, 5'h04, 32'h0, 4'h0, 0, 0, 0, 12, 0, 2'b00, 32'hCAFE_0001, "t5_timeout");
        run_txn(1'b0, 5'h10, 32'h0, 4'h0, 1, 0, 0, TO - 1, 0, 2'b01, 32'h0BAD_F00D, "edge_hs_wins");
        run_txn(1'b1, 5'h1C, 32'h55AA_55AA, 4'b1010, 1, 1, 0, TO, 2, 2'b00, 32'h0, "edge_wr_timeout");

        // reset while the write address phase is pending
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 5'h18; cmd_wdata = 32'h0F0F_0F0F; cmd_wstrb = 4'hF;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("t6 in waddr", 64'({awvalid, wvalid, cmd_ready}), 64'b110);
        @(posedge clk);
        #1;
        aresetn = 1'b0;
        @(posedge clk);
        #1;
        check("t6 reset ctrl", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}), 64'h01);
        aresetn = 1'b1;
        run_txn(1'b0, 5'h14, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h0000_00A5, "t6_after");

        // randomized traffic
        for (int i = 0; i < 24; i++) begin
            we  = 1'($urandom);
            dly = ($urandom_range(0, 3) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, TO - 1);
            run_txn(we, 5'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), dly, $urandom_range(0, 2), 2'($urandom), $urandom,
                    $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
